// File: rtl/power_pkg.sv
// Shared definitions for the power button front end and the power switch FSM.
//   - gesture_state_t : 3-bit gesture classifier state encoding
//   - CLK_HZ_MIN/MAX  : legal system clock range for the power blocks
//   - ms_to_cyc()     : milliseconds to clock cycles at a given clock rate
package power_pkg;

  localparam int unsigned CLK_HZ_MIN = 1000;
  localparam int unsigned CLK_HZ_MAX = 150_000_000;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_PRESS        = 3'd1,
    ST_LONG_HELD    = 3'd2,
    ST_WAIT_SECOND  = 3'd3,
    ST_SECOND_PRESS = 3'd4
  } gesture_state_t;

  // Integer kHz first so the product stays inside 32 bits for any legal clock.
  function automatic logic [31:0] ms_to_cyc(input int unsigned clk_hz,
                                            input int unsigned ms);
    return (clk_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser plus debounce counter for an active-low pad.
//   clk, rst_n : clock, async active-low reset
//   btn_n      : raw pad, active-low, asynchronous to clk
//   pressed    : debounced level, 1 = pressed
//   rise, fall : one-cycle strobes, coincident with the pressed level change
module button_debouncer
  import power_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned DEBOUNCE_MS = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic pressed,
  output logic rise,
  output logic fall
);

  localparam logic [31:0] DB_CYC  = ms_to_cyc(CLK_HZ, DEBOUNCE_MS);
  // Flip on the edge where the count would reach DB_CYC, giving 2 + DB_CYC
  // cycles from a stable pad edge to the level change.
  localparam logic [31:0] DB_LAST = (DB_CYC == 32'd0) ? 32'd0 : DB_CYC - 32'd1;

  logic        sync1_n, sync2_n, level_n;
  logic [31:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_n <= 1'b1;
      sync2_n <= 1'b1;
      level_n <= 1'b1;
      cnt     <= '0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      sync1_n <= btn_n;
      sync2_n <= sync1_n;
      rise    <= 1'b0;
      fall    <= 1'b0;
      if (sync2_n == level_n) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        cnt     <= '0;
        level_n <= sync2_n;
        rise    <= ~sync2_n;
        fall    <= sync2_n;
      end else begin
        cnt <= cnt + 32'd1;
      end
    end
  end

  assign pressed = ~level_n;

endmodule

// File: rtl/power_button_decoder.sv
// Power button front end: debounced level for the power switch FSM and
// one-cycle gesture events (short / double / long) for firmware.
//   clk, rst_n   : clock, async active-low reset
//   btn_n        : raw pad, active-low, asynchronous
//   btn_pressed  : debounced level, 1 = pressed
//   short_press  : single click confirmed (gap expired)
//   double_press : second click released
//   long_press   : hold reached LONG_MS
module power_button_decoder
  import power_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 100_000_000,
  parameter int unsigned DEBOUNCE_MS   = 20,
  parameter int unsigned SHORT_MAX_MS  = 1000,
  parameter int unsigned LONG_MS       = 3000,
  parameter int unsigned DOUBLE_GAP_MS = 300
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic btn_pressed,
  output logic short_press,
  output logic double_press,
  output logic long_press
);

  if (CLK_HZ < CLK_HZ_MIN || CLK_HZ > CLK_HZ_MAX) begin : g_bad_clk
    $error("power_button_decoder: CLK_HZ %0d outside legal range", CLK_HZ);
  end
  if (LONG_MS <= SHORT_MAX_MS) begin : g_bad_long
    $error("power_button_decoder: LONG_MS must exceed SHORT_MAX_MS");
  end

  localparam logic [31:0] TICK_LAST = ms_to_cyc(CLK_HZ, 1) - 32'd1;
  localparam logic [15:0] SHORT_C   = 16'(SHORT_MAX_MS);
  localparam logic [15:0] LONG_C    = 16'(LONG_MS);
  localparam logic [15:0] GAP_C     = 16'(DOUBLE_GAP_MS);

  logic db_rise, db_fall;

  button_debouncer #(
    .CLK_HZ      (CLK_HZ),
    .DEBOUNCE_MS (DEBOUNCE_MS)
  ) u_db (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_n   (btn_n),
    .pressed (btn_pressed),
    .rise    (db_rise),
    .fall    (db_fall)
  );

  // Free-running 1 ms prescaler; not aligned to presses, hence +-1 ms timing.
  logic [31:0] pre;
  logic        tick;
  assign tick = (pre == TICK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    pre <= '0;
    else if (tick) pre <= '0;
    else           pre <= pre + 32'd1;
  end

  gesture_state_t state, state_nxt;
  logic [15:0]    ms_cnt, ms_nxt, ms_inc;
  logic           short_nxt, double_nxt, long_nxt;

  assign ms_inc = (ms_cnt == 16'hFFFF) ? ms_cnt : ms_cnt + 16'd1;

  // Thresholds compare the value the tick would store, so an event fires on
  // the tick that brings ms_cnt to its limit. Debounced edges are tested
  // first, so an edge always beats a coincident tick (including a press at
  // the exact cycle the double-click gap runs out).
  always_comb begin
    state_nxt  = state;
    ms_nxt     = ms_cnt;
    short_nxt  = 1'b0;
    double_nxt = 1'b0;
    long_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (db_rise) begin
          ms_nxt    = '0;
          state_nxt = ST_PRESS;
        end
      end
      ST_PRESS: begin
        if (db_fall) begin
          if (ms_cnt < SHORT_C) begin
            ms_nxt    = '0;
            state_nxt = ST_WAIT_SECOND;
          end else begin
            state_nxt = ST_IDLE;  // too long for a click, too short to be long
          end
        end else if (tick) begin
          if (ms_inc >= LONG_C) begin
            long_nxt  = 1'b1;
            state_nxt = ST_LONG_HELD;
          end else begin
            ms_nxt = ms_inc;
          end
        end
      end
      ST_LONG_HELD: begin
        if (db_fall) state_nxt = ST_IDLE;
      end
      ST_WAIT_SECOND: begin
        if (db_rise) begin
          ms_nxt    = '0;
          state_nxt = ST_SECOND_PRESS;
        end else if (tick) begin
          if (ms_inc >= GAP_C) begin
            short_nxt = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            ms_nxt = ms_inc;
          end
        end
      end
      ST_SECOND_PRESS: begin
        if (db_fall) begin
          double_nxt = 1'b1;
          state_nxt  = ST_IDLE;
        end else if (tick) begin
          if (ms_inc >= LONG_C) begin
            long_nxt  = 1'b1;       // first click is dropped
            state_nxt = ST_LONG_HELD;
          end else begin
            ms_nxt = ms_inc;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        ms_nxt    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      ms_cnt       <= '0;
      short_press  <= 1'b0;
      double_press <= 1'b0;
      long_press   <= 1'b0;
    end else begin
      state        <= state_nxt;
      ms_cnt       <= ms_nxt;
      short_press  <= short_nxt;
      double_press <= double_nxt;
      long_press   <= long_nxt;
    end
  end

endmodule
